// File: rtl/xfade_pkg.sv
// Shared types and default sizing for the crossfading source selector.
package xfade_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_FADE_LOG2 = 6;

endpackage

// File: rtl/xfade_mac.sv
// Combinational weighted sum (a*(N-k) + b*k) >>> FADE_LOG2 with floor rounding.
// Intermediates carry WIDTH+FADE_LOG2+2 signed bits, so the sum never overflows
// and the result is a convex combination that always fits back into WIDTH bits.
module xfade_mac #(
  parameter int WIDTH     = 16,
  parameter int FADE_LOG2 = 6
) (
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic        [FADE_LOG2-1:0] k,
  output logic signed [WIDTH-1:0]     y
);

  localparam int IW = WIDTH + FADE_LOG2 + 2;
  localparam logic signed [IW-1:0] N_S = IW'(2 ** FADE_LOG2);

  // Divide by N with the arithmetic shift, i.e. floor toward negative infinity.
  function automatic logic signed [WIDTH-1:0] floor_div_n(input logic signed [IW-1:0] s);
    return WIDTH'(s >>> FADE_LOG2);
  endfunction

  logic signed [IW-1:0] a_x, b_x, w_a, w_b, sum;

  // Blend the two sources with complementary weights N-k and k.
  always_comb begin
    a_x = IW'(a);
    b_x = IW'(b);
    w_b = $signed({{(IW-FADE_LOG2){1'b0}}, k});
    w_a = N_S - w_b;
    sum = a_x * w_a + b_x * w_b;
    y   = floor_div_n(sum);
  end

endmodule

// File: rtl/xfade_mux.sv
// Click-free source selector: switching sources crossfades over N = 2**FADE_LOG2
// samples. All state advances only on sample_valid; outputs are registered.
// Optional macro XFADE_MUX_MUTE_EN adds a mute input that fades to/from silence.
module xfade_mux
  import xfade_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int FADE_LOG2 = DEF_FADE_LOG2,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      sample_valid,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
`ifdef XFADE_MUX_MUTE_EN
  input  logic                      mute,
`endif
  output logic signed [WIDTH-1:0]   dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic [SEL_W-1:0]          active_sel
);

  localparam logic [FADE_LOG2-1:0] K_LAST = '1;
  localparam logic [FADE_LOG2-1:0] K_ONE  = FADE_LOG2'(1);

  state_t                  state_q, state_d;
  logic [FADE_LOG2-1:0]    k_q, k_d;
  logic [SEL_W-1:0]        target_q, target_d;
  logic [SEL_W-1:0]        active_sel_q, active_sel_d;
  logic signed [WIDTH-1:0] dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    busy_q, busy_d;
  logic signed [WIDTH-1:0] ch_a, ch_b, mac_a, mac_b, mac_y;
  logic                    sel_ok;

  // k is 0 whenever the FSM is idle, so the blend then passes source a straight
  // through; this also yields the k=0 value on the sample that starts a fade.
  assign ch_a   = din[active_sel_q*WIDTH +: WIDTH];
  assign ch_b   = din[target_q*WIDTH +: WIDTH];
  assign sel_ok = int'(sel) < CHANNELS;

`ifdef XFADE_MUX_MUTE_EN
  // muted_q is the fully applied mute state; tmute_q is where the fade ends.
  logic muted_q, muted_d, tmute_q, tmute_d;
  assign mac_a = muted_q ? '0 : ch_a;
  assign mac_b = tmute_q ? '0 : ch_b;
`else
  assign mac_a = ch_a;
  assign mac_b = ch_b;
`endif

  xfade_mac #(
    .WIDTH    (WIDTH),
    .FADE_LOG2(FADE_LOG2)
  ) u_mac (
    .a(mac_a),
    .b(mac_b),
    .k(k_q),
    .y(mac_y)
  );

  // Next-state logic: fade start/advance/finish, evaluated only on a sample strobe.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    target_d     = target_q;
    active_sel_d = active_sel_q;
    dout_d       = dout_q;
    busy_d       = busy_q;
    dout_valid_d = sample_valid;
`ifdef XFADE_MUX_MUTE_EN
    muted_d      = muted_q;
    tmute_d      = tmute_q;
`endif
    if (sample_valid) begin
      dout_d = mac_y;
      case (state_q)
        IDLE: begin
`ifdef XFADE_MUX_MUTE_EN
          // A mute edge fades the current source toward/away from silence.
          if (mute != muted_q) begin
            tmute_d  = mute;
            target_d = active_sel_q;
            state_d  = FADE;
            k_d      = K_ONE;
          end else
`endif
          if (sel != active_sel_q && sel_ok) begin
            target_d = sel;
            state_d  = FADE;
            k_d      = K_ONE;
          end
        end
        FADE: begin
          // Requests arriving mid-fade are ignored; they are re-evaluated in IDLE.
          if (k_q == K_LAST) begin
            state_d      = IDLE;
            k_d          = '0;
            active_sel_d = target_q;
`ifdef XFADE_MUX_MUTE_EN
            muted_d      = tmute_q;
`endif
          end else begin
            k_d = k_q + K_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
      busy_d = (state_d == FADE);
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      target_q     <= '0;
      active_sel_q <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef XFADE_MUX_MUTE_EN
      muted_q      <= 1'b0;
      tmute_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      target_q     <= target_d;
      active_sel_q <= active_sel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
`ifdef XFADE_MUX_MUTE_EN
      muted_q      <= muted_d;
      tmute_q      <= tmute_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign active_sel = active_sel_q;

endmodule

// File: tb/tb_xfade_mux.sv
// Scoreboard bench for xfade_mux (WIDTH=16, CHANNELS=4, FADE_LOG2=2, N=4).
// Expected dout values are queued as samples are issued; a negedge monitor
// pops and compares whenever dout_valid is high.
module tb_xfade_mux;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int FL = 2;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic                 sample_valid = 1'b0;
  logic [CH*W-1:0]      din = '0;
  logic [1:0]           sel = '0;
`ifdef XFADE_MUX_MUTE_EN
  logic                 mute = 1'b0;
`endif
  logic signed [W-1:0]  dout;
  logic                 dout_valid;
  logic                 busy;
  logic [1:0]           active_sel;

  int total  = 0;
  int passed = 0;
  logic signed [W-1:0] exp_q[$];

  xfade_mux #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .FADE_LOG2(FL)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .sample_valid(sample_valid),
    .din         (din),
    .sel         (sel),
`ifdef XFADE_MUX_MUTE_EN
    .mute        (mute),
`endif
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .active_sel  (active_sel)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every presented output must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (dout_valid) begin
      if (exp_q.size() == 0) chk("unexpected_dout_valid", 1, 0);
      else chk("dout", int'(dout), int'(exp_q.pop_front()));
    end
  end

  task automatic set_ch(input int idx, input int val);
    din[idx*W +: W] = W'(val);
  endtask

  // One sample strobe with the expected registered output queued.
  task automatic strobe(input logic [1:0] s, input int e);
    @(posedge Clk); #1;
    sel          = s;
    sample_valid = 1'b1;
    exp_q.push_back(W'(e));
    @(posedge Clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active_sel", int'(active_sel), 0);
    Reset_n = 1'b1;

    // Switch 0 -> 1
    set_ch(0, 1000);
    set_ch(1, -1000);
    strobe(2'd1, 1000);
    chk("sw_busy_k0", int'(busy), 1);
    chk("sw_active_k0", int'(active_sel), 0);
    strobe(2'd1, 500);
    strobe(2'd1, 0);
    chk("sw_busy_k2", int'(busy), 1);
    strobe(2'd1, -500);
    chk("sw_busy_end", int'(busy), 0);
    chk("sw_active_end", int'(active_sel), 1);
    strobe(2'd1, -1000);

    // Latency and hold
    @(posedge Clk); #1;
    sel          = 2'd1;
    sample_valid = 1'b1;
    exp_q.push_back(W'(-1000));
    #1;
    chk("lat_valid_before", int'(dout_valid), 0);
    @(posedge Clk); #1;
    sample_valid = 1'b0;
    chk("lat_valid_after", int'(dout_valid), 1);
    set_ch(1, 5);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      chk("hold_valid", int'(dout_valid), 0);
      chk("hold_dout", int'(dout), -1000);
    end
    set_ch(1, -1000);

    // Fade 1 -> 0 to return to source 0
    strobe(2'd0, -1000);
    strobe(2'd0, -500);
    strobe(2'd0, 0);
    strobe(2'd0, 500);
    strobe(2'd0, 1000);
    chk("back_active", int'(active_sel), 0);

    // Mid-fade sel change: 0->1 completes, then 1->2 starts immediately
    set_ch(2, 2000);
    strobe(2'd1, 1000);
    strobe(2'd2, 500);
    strobe(2'd2, 0);
    strobe(2'd2, -500);
    chk("mid_active_after_first", int'(active_sel), 1);
    chk("mid_busy_after_first", int'(busy), 0);
    strobe(2'd2, -1000);
    chk("mid_busy_second", int'(busy), 1);
    strobe(2'd2, -250);
    strobe(2'd2, 500);
    strobe(2'd2, 1250);
    chk("mid_active_end", int'(active_sel), 2);
    chk("mid_busy_end", int'(busy), 0);
    strobe(2'd2, 2000);

    // Reset mid-fade, no clock edge involved
    set_ch(3, 0);
    strobe(2'd3, 2000);
    strobe(2'd3, 1500);
    chk("pre_rst_busy", int'(busy), 1);
    @(negedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_dout", int'(dout), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_active", int'(active_sel), 0);
    chk("arst_valid", int'(dout_valid), 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    strobe(2'd0, 1000);
    chk("post_rst_busy", int'(busy), 0);

    // Asymmetric floor: -1 toward 0
    set_ch(0, -1);
    set_ch(1, 0);
    strobe(2'd1, -1);
    strobe(2'd1, -1);
    strobe(2'd1, -1);
    strobe(2'd1, -1);
    strobe(2'd1, 0);
    chk("floor_active", int'(active_sel), 1);

`ifdef XFADE_MUX_MUTE_EN
    // Mute fade out and back in on source 0
    set_ch(0, 800);
    set_ch(1, 0);
    strobe(2'd0, 0);
    strobe(2'd0, 200);
    strobe(2'd0, 400);
    strobe(2'd0, 600);
    mute = 1'b1;
    strobe(2'd0, 800);
    strobe(2'd0, 600);
    strobe(2'd0, 400);
    strobe(2'd0, 200);
    strobe(2'd0, 0);
    strobe(2'd0, 0);
    strobe(2'd0, 0);
    chk("mute_busy_held", int'(busy), 0);
    mute = 1'b0;
    strobe(2'd0, 0);
    strobe(2'd0, 200);
    strobe(2'd0, 400);
    strobe(2'd0, 600);
    strobe(2'd0, 800);
`endif

    repeat (3) @(posedge Clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xfade_mux.md
XFADE_MUX -- requirements
Module: xfade_mux

Interface
REQ-001 Parameter WIDTH, default 16, is the signed two's-complement audio sample width.
REQ-002 Parameter CHANNELS, default 4, is the number of selectable sources; legal range is 2..16.
REQ-003 Parameter FADE_LOG2, default 6, sets the crossfade length N = 2**FADE_LOG2 samples; legal range is 1..10.
REQ-004 Clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 Reset_n  input  1  is the asynchronous, active-low reset.
REQ-006 sample_valid  input  1  is a one-cycle strobe per audio sample.
REQ-007 din  input  CHANNELS*WIDTH  carries the packed sources; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 sel  input  $clog2(CHANNELS)  is the requested source.
REQ-009 dout  output  WIDTH  is the registered output sample.
REQ-010 dout_valid  output  1  pulses once per accepted sample.
REQ-011 busy  output  1  is high while a crossfade is in progress.
REQ-012 active_sel  output  $clog2(CHANNELS)  is the source currently fully selected.

Function
REQ-013 The block shall update state, counter and outputs only in cycles where sample_valid=1; all outputs shall hold otherwise.
REQ-014 Latency shall be 1 cycle: dout and dout_valid=1 appear in the cycle after sample_valid; dout_valid is low in all other cycles.
REQ-015 FSM states shall be IDLE and FADE.
- IDLE: dout = din[active_sel].
- FADE: a = din[active_sel], b = din[target], k = fade counter.
REQ-016 In IDLE, a sample with sel != active_sel and sel < CHANNELS shall latch target=sel, enter FADE and emit the k=0 value for that same sample.
REQ-017 FADE output shall be (a*(N-k) + b*k) >>> FADE_LOG2, using signed intermediates of WIDTH+FADE_LOG2+2 bits; the arithmetic shift floors toward negative infinity and the result never saturates.
REQ-018 k shall increment once per sample.
- At the sample with k=N-1, the next state is IDLE and active_sel becomes target.
- A fade therefore spans exactly N samples.
REQ-019 sel changes during FADE shall be ignored; after the return to IDLE, a differing sel starts a new fade on the next sample.
REQ-020 sel >= CHANNELS (non-power-of-2 CHANNELS) shall be ignored; active_sel is unchanged.
REQ-021 busy shall be high from the cycle after the fade-starting sample until the cycle after the k=N-1 sample.

Reset
REQ-022 Assertion of Reset_n=0 shall, asynchronously and at any time (including mid-fade), set state=IDLE, k=0, target=0, active_sel=0, dout=0, dout_valid=0, busy=0.
REQ-023 The first sample_valid after deassertion shall be processed normally.

Configuration
REQ-024 With macro XFADE_MUX_MUTE_EN defined, the block shall add input port mute (1 bit).
- A rising mute fades to 0 (b=0) over N samples.
- Output then holds 0 while mute=1.
- A falling mute fades from 0 to din[active_sel] over N samples.
- Mute edges during FADE are deferred, like sel changes.
REQ-025 Without XFADE_MUX_MUTE_EN, the mute port and its logic shall be absent and behaviour shall be exactly REQ-013..REQ-021.

Structure
REQ-026 Package xfade_pkg shall hold the FSM state typedef (IDLE, FADE) and the default WIDTH/CHANNELS/FADE_LOG2 constants.
REQ-027 Sub-module xfade_mac shall hold the combinational weighted-sum datapath (a, b, k -> result); the FSM, counter and output registers stay in xfade_mux.

Verification (WIDTH=16, CHANNELS=4, FADE_LOG2=2, N=4)
REQ-028 Switch: ch0=1000, ch1=-1000, sel 0->1, then strobes. Required dout sequence is 1000, 500, 0, -500, -1000. busy is high for 4 samples, then active_sel=1.
REQ-029 Latency and hold: single sample_valid. Required response is dout_valid high exactly 1 cycle later; dout unchanged across 10 idle cycles.
REQ-030 Mid-fade sel change: sel=2 at fade k=1. Required response is a 0->1 fade completing unchanged, followed immediately by a 1->2 fade.
REQ-031 Reset mid-fade: Reset_n=0 at k=2 with no clock edge. Required response is dout=0, busy=0, active_sel=0 immediately.
REQ-032 Asymmetric floor: ch0=-1, ch1=0, fade 0->1. Required dout sequence is -1, -1, -1, -1, 0.
REQ-033 With XFADE_MUX_MUTE_EN defined: ch0=800, raise mute. Required dout sequence is 800, 600, 400, 200, 0, held at 0; on mute release, 0, 200, 400, 600, 800.
